soc_system_irq_ctrl: RTL and testbench

SOC_SYSTEM_IRQ_CTRL -- requirements
Module: soc_system_irq_ctrl

---
 rtl/soc_system_irq_ctrl_pkg.sv | 32 +++
 rtl/soc_system_irq_sync.sv | 46 ++++
 rtl/soc_system_irq_ctrl.sv | 146 ++++++++++++++
 tb/tb_soc_system_irq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, source limit,
// VECTOR field layout and the lowest-set-bit encoder.
package soc_system_irq_ctrl_pkg;

  localparam int unsigned NUM_SRC_MAX   = 15;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned VEC_VALID_BIT = 15;
  localparam int unsigned VEC_IDX_LSB   = 0;
  localparam int unsigned VEC_IDX_W     = 4;

  typedef enum logic [2:0] {
    ADDR_PENDING = 3'd0,
    ADDR_MASK    = 3'd1,
    ADDR_EDGE    = 3'd2,
    ADDR_STATUS  = 3'd3,
    ADDR_VECTOR  = 3'd4,
    ADDR_FORCE   = 3'd5,
    ADDR_CTRL    = 3'd6,
    ADDR_RSVD    = 3'd7
  } reg_addr_e;

  // Scanning from the top down leaves the lowest set index as the final value.
  function automatic logic [VEC_IDX_W-1:0] lowest_idx(input logic [NUM_SRC_MAX-1:0] v);
    logic [VEC_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_SRC_MAX; i++) begin
      if (v[NUM_SRC_MAX-1-i]) idx = VEC_IDX_W'(NUM_SRC_MAX-1-i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/soc_system_irq_sync.sv
// Two-flop synchronizer for one interrupt source; with SOC_SYSTEM_IRQ_CTRL_EDGE_EN
// defined, a third flop provides a rising-edge pulse.
module soc_system_irq_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
`ifdef SOC_SYSTEM_IRQ_CTRL_EDGE_EN
  output logic rise_o,
`endif
  output logic sync_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sync_o = sync2_q;

`ifdef SOC_SYSTEM_IRQ_CTRL_EDGE_EN
  logic sync3_q, sync3_d;

  always_comb sync3_d = sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync3_q <= 1'b0;
    else          sync3_q <= sync3_d;
  end

  assign rise_o = sync2_q & ~sync3_q;
`endif

endmodule

// File: rtl/soc_system_irq_ctrl.sv
// Avalon-MM interrupt controller: level/forced sources, mask, priority vector.
// Rising-edge latching is built only with SOC_SYSTEM_IRQ_CTRL_EDGE_EN defined.
module soc_system_irq_ctrl
  import soc_system_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  logic [NUM_SRC-1:0] sync2;
  logic [NUM_SRC-1:0] soft_q, soft_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               ctrl_q, ctrl_d;
  logic [15:0]        readdata_q, readdata_d;
  logic [NUM_SRC-1:0] pending, masked, edge_rd;
  logic [NUM_SRC-1:0] w1c, force_set;
  logic               wr_en;
  logic               unused_wd;

  function automatic logic [15:0] zext(input logic [NUM_SRC-1:0] v);
    logic [15:0] r;
    r = '0;
    r[NUM_SRC-1:0] = v;
    return r;
  endfunction

`ifdef SOC_SYSTEM_IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [NUM_SRC-1:0] latch_q, latch_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    soc_system_irq_sync u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (irq_in[g]),
      .rise_o (rise[g]),
      .sync_o (sync2[g])
    );
  end

  // A latched bit stays pending even after EDGE is cleared; only W1C removes it.
  assign pending = latch_q | soft_q | (sync2 & ~edge_q);
  assign edge_rd = edge_q;
`else
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    soc_system_irq_sync u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (irq_in[g]),
      .sync_o (sync2[g])
    );
  end

  assign pending = sync2 | soft_q;
  assign edge_rd = '0;
`endif

  assign masked    = pending & mask_q;
  assign irq       = ctrl_q & (|masked);
  assign readdata  = readdata_q;
  assign unused_wd = ^writedata;

  always_comb begin
    wr_en     = chipselect & ~write_n;
    w1c       = '0;
    force_set = '0;
    mask_d    = mask_q;
    ctrl_d    = ctrl_q;
    if (wr_en) begin
      case (reg_addr_e'(address))
        ADDR_PENDING: w1c       = writedata[NUM_SRC-1:0];
        ADDR_MASK:    mask_d    = writedata[NUM_SRC-1:0];
        ADDR_FORCE:   force_set = writedata[NUM_SRC-1:0];
        ADDR_CTRL:    ctrl_d    = writedata[0];
        default:      ;
      endcase
    end
    // Set terms are OR'd after the clear so a same-cycle set always wins.
    soft_d = (soft_q & ~w1c) | force_set;
  end

`ifdef SOC_SYSTEM_IRQ_CTRL_EDGE_EN
  always_comb begin
    edge_d = edge_q;
    if (wr_en && reg_addr_e'(address) == ADDR_EDGE) edge_d = writedata[NUM_SRC-1:0];
    latch_d = (latch_q & ~w1c) | (rise & edge_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q  <= '0;
      latch_q <= '0;
    end else begin
      edge_q  <= edge_d;
      latch_q <= latch_d;
    end
  end
`endif

  always_comb begin
    logic [NUM_SRC_MAX-1:0] masked_ext;
    logic [15:0]            vector;
    masked_ext = '0;
    masked_ext[NUM_SRC-1:0] = masked;
    vector = '0;
    if (|masked) begin
      vector[VEC_VALID_BIT]                = 1'b1;
      vector[VEC_IDX_LSB +: VEC_IDX_W]     = lowest_idx(masked_ext);
    end
    readdata_d = '0;
    case (reg_addr_e'(address))
      ADDR_PENDING: readdata_d = zext(pending);
      ADDR_MASK:    readdata_d = zext(mask_q);
      ADDR_EDGE:    readdata_d = zext(edge_rd);
      ADDR_STATUS:  readdata_d = zext(masked);
      ADDR_VECTOR:  readdata_d = vector;
      ADDR_CTRL:    readdata_d = {15'd0, ctrl_q};
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      soft_q     <= '0;
      mask_q     <= '0;
      ctrl_q     <= 1'b0;
      readdata_q <= '0;
    end else begin
      soft_q     <= soft_d;
      mask_q     <= mask_d;
      ctrl_q     <= ctrl_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_soc_system_irq_ctrl.sv
// Directed bench for soc_system_irq_ctrl; edge-latch scenarios run only when
// SOC_SYSTEM_IRQ_CTRL_EDGE_EN is defined, otherwise EDGE-disabled behaviour is checked.
module tb_soc_system_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [7:0]  irq_in = '0;
  logic        irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  soc_system_irq_ctrl #(.NUM_SRC(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq_in    (irq_in),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (readdata !== 16'h0000) begin n_err++; $display("FAIL reset_readdata got=%h exp=0000", readdata); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
    reset_n = 1'b1;
    rd(3'd1, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL reset_mask got=%h exp=0000", v); end
    rd(3'd6, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL reset_ctrl got=%h exp=0000", v); end
    rd(3'd0, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL reset_pending got=%h exp=0000", v); end
  endtask

  task automatic test_level();
    logic [15:0] v;
    wr(3'd1, 16'h0001);
    wr(3'd6, 16'h0001);
    irq_in[0] = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL level_irq_edgeN got=%b exp=0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL level_irq_edgeN1 got=%b exp=1", irq); end
    rd(3'd0, v);
    n_cmp++; if (v !== 16'h0001) begin n_err++; $display("FAIL level_pending got=%h exp=0001", v); end
    rd(3'd3, v);
    n_cmp++; if (v !== 16'h0001) begin n_err++; $display("FAIL level_status got=%h exp=0001", v); end
    rd(3'd4, v);
    n_cmp++; if (v !== 16'h8000) begin n_err++; $display("FAIL level_vector got=%h exp=8000", v); end
    @(negedge clk);
    irq_in[0] = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL level_drop_edge1 got=%b exp=1", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL level_drop_edge2 got=%b exp=0", irq); end
  endtask

  task automatic test_priority();
    logic [15:0] v;
    wr(3'd1, 16'h00FF);
    wr(3'd5, 16'h0050);
    rd(3'd4, v);
    n_cmp++; if (v !== 16'h8004) begin n_err++; $display("FAIL prio_vec1 got=%h exp=8004", v); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL prio_irq1 got=%b exp=1", irq); end
    wr(3'd0, 16'h0010);
    rd(3'd4, v);
    n_cmp++; if (v !== 16'h8006) begin n_err++; $display("FAIL prio_vec2 got=%h exp=8006", v); end
    wr(3'd0, 16'h0040);
    rd(3'd4, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL prio_vec3 got=%h exp=0000", v); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL prio_irq3 got=%b exp=0", irq); end
    wr(3'd5, 16'h0000);
    rd(3'd0, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL force_zero_pending got=%h exp=0000", v); end
  endtask

  task automatic test_mask_enable();
    logic [15:0] v;
    irq_in = 8'h03;
    wr(3'd1, 16'h0002);
    rd(3'd3, v);
    n_cmp++; if (v !== 16'h0002) begin n_err++; $display("FAIL mask_status got=%h exp=0002", v); end
    wr(3'd0, 16'h0003);
    rd(3'd0, v);
    n_cmp++; if (v !== 16'h0003) begin n_err++; $display("FAIL level_w1c_pending got=%h exp=0003", v); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL mask_irq got=%b exp=1", irq); end
    wr(3'd6, 16'h0000);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL disable_irq got=%b exp=0", irq); end
    rd(3'd3, v);
    n_cmp++; if (v !== 16'h0002) begin n_err++; $display("FAIL disable_status got=%h exp=0002", v); end
    irq_in = 8'h00;
    wr(3'd6, 16'h0001);
  endtask

  task automatic test_upper_bits();
    logic [15:0] v;
    wr(3'd1, 16'hFFFF);
    rd(3'd1, v);
    n_cmp++; if (v !== 16'h00FF) begin n_err++; $display("FAIL mask_upper got=%h exp=00FF", v); end
    rd(3'd7, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL addr7 got=%h exp=0000", v); end
    wr(3'd2, 16'hFFFF);
    rd(3'd2, v);
`ifdef SOC_SYSTEM_IRQ_CTRL_EDGE_EN
    n_cmp++; if (v !== 16'h00FF) begin n_err++; $display("FAIL edge_upper got=%h exp=00FF", v); end
`else
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL edge_disabled got=%h exp=0000", v); end
`endif
    wr(3'd2, 16'h0000);
  endtask

  task automatic test_edge();
    logic [15:0] v;
    wr(3'd1, 16'h0004);
`ifdef SOC_SYSTEM_IRQ_CTRL_EDGE_EN
    wr(3'd2, 16'h0004);
    irq_in[2] = 1'b1;
    @(negedge clk); irq_in[2] = 1'b0;
    repeat (12) @(posedge clk);
    rd(3'd0, v);
    n_cmp++; if (v !== 16'h0004) begin n_err++; $display("FAIL edge_latched got=%h exp=0004", v); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL edge_irq got=%b exp=1", irq); end
    wr(3'd0, 16'h0004);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL edge_w1c_irq got=%b exp=0", irq); end
    rd(3'd0, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL edge_w1c_pending got=%h exp=0000", v); end
    // Pulse so the latch sets on the same edge that carries the W1C.
    @(negedge clk); irq_in[2] = 1'b1;
    @(negedge clk); irq_in[2] = 1'b0;
    @(negedge clk); chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 16'h0004;
    @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
    rd(3'd0, v);
    n_cmp++; if (v !== 16'h0004) begin n_err++; $display("FAIL edge_simul got=%h exp=0004", v); end
    wr(3'd2, 16'h0000);
    rd(3'd0, v);
    n_cmp++; if (v !== 16'h0004) begin n_err++; $display("FAIL edge_clr_keeps got=%h exp=0004", v); end
    wr(3'd0, 16'h0004);
`else
    wr(3'd2, 16'hFFFF);
    irq_in[2] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL noedge_level_irq got=%b exp=1", irq); end
    @(negedge clk); irq_in[2] = 1'b0;
    repeat (4) @(posedge clk);
    rd(3'd0, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL noedge_no_latch got=%h exp=0000", v); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL noedge_irq_low got=%b exp=0", irq); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    wr(3'd5, 16'h00FF);
    wr(3'd1, 16'h00FF);
    rd(3'd0, v);
    n_cmp++; if (v !== 16'h00FF) begin n_err++; $display("FAIL mid_pre_pending got=%h exp=00FF", v); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (readdata !== 16'h0000) begin n_err++; $display("FAIL mid_readdata got=%h exp=0000", readdata); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_irq got=%b exp=0", irq); end
    @(negedge clk); reset_n = 1'b1;
    rd(3'd0, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL mid_pending got=%h exp=0000", v); end
    rd(3'd1, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL mid_mask got=%h exp=0000", v); end
    wr(3'd2, 16'hFFFF);
    rd(3'd2, v);
`ifdef SOC_SYSTEM_IRQ_CTRL_EDGE_EN
    n_cmp++; if (v !== 16'h00FF) begin n_err++; $display("FAIL mid_edge got=%h exp=00FF", v); end
`else
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL mid_edge got=%h exp=0000", v); end
`endif
  endtask

  initial begin
    test_reset();
    test_level();
    test_priority();
    test_mask_enable();
    test_upper_bits();
    test_edge();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
